// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Wide enough for any TIMEOUT up to 256 cycles.
  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  int idx;

  // Scan from the farthest offset back to ptr so the nearest valid request wins.
  always_comb begin
    gnt = '0;
    idx = 0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % N;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one st/done multiplier among N_REQ requesters with round-robin grants
// and a WAIT-state timeout that returns an error response.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_mcand,
  input  logic [N_REQ*W-1:0]       req_mplier,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [2*W-1:0]           rsp_product,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mul_st,
  output logic [W-1:0]             mul_mcand,
  output logic [W-1:0]             mul_mplier,
  input  logic                     mul_done,
  input  logic [2*W-1:0]           mul_product
);

  localparam int IDW = $clog2(N_REQ);

  state_t           state_reg, state_next;
  logic [IDW-1:0]   rr_ptr_reg, id_reg, rsp_id_reg, win_id;
  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     mcand_reg, mplier_reg;
  logic [2*W-1:0]   product_reg;
  logic             err_reg;
  logic [N_REQ-1:0] gnt;
  logic             arb_en;
  logic             cnt_expired;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign arb_en      = (state_reg == IDLE) && rst_n;
  assign cnt_expired = (cnt_reg == CNT_W'(TIMEOUT - 1));

  rr_arbiter #(.N(N_REQ), .PW(IDW)) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_id = IDW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    mul_st     = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        req_ready = gnt;
        if (|gnt) state_next = ISSUE;
      end
      ISSUE: begin
        mul_st     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (mul_done || cnt_expired) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      id_reg      <= '0;
      rsp_id_reg  <= '0;
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|gnt) begin
            mcand_reg  <= req_mcand[int'(win_id)*W +: W];
            mplier_reg <= req_mplier[int'(win_id)*W +: W];
            id_reg     <= win_id;
            rr_ptr_reg <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);
          end
        end
        ISSUE: cnt_reg <= '0;
        WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (mul_done) begin
            product_reg <= mul_product;
            err_reg     <= 1'b0;
            rsp_id_reg  <= id_reg;
          end else if (cnt_expired) begin
            product_reg <= '0;
            err_reg     <= 1'b1;
            rsp_id_reg  <= id_reg;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_mcand   = mcand_reg;
  assign mul_mplier  = mplier_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_product = product_reg;
  assign rsp_err     = err_reg;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a behavioural
// st/done multiplier whose latency (or absence of done) is set per step.
module tb_mul_share_arbiter;

  localparam int N_REQ   = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*W-1:0]   req_mcand = '0;
  logic [N_REQ*W-1:0]   req_mplier = '0;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [2*W-1:0]       rsp_product;
  logic                 rsp_err;
  logic                 busy;
  logic                 mul_st;
  logic [W-1:0]         mul_mcand;
  logic [W-1:0]         mul_mplier;
  logic                 mul_done;
  logic [2*W-1:0]       mul_product;

  int n_assert = 0;
  int n_fail   = 0;

  // Multiplier model: done pulses model_lat cycles after st; 0 means never.
  int        model_lat = 1;
  logic      spur_done = 1'b0;
  logic      m_busy, m_done;
  int        m_cnt;
  logic [3:0] m_a, m_b;
  logic [7:0] m_prod;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mcand   (req_mcand),
    .req_mplier  (req_mplier),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .mul_st      (mul_st),
    .mul_mcand   (mul_mcand),
    .mul_mplier  (mul_mplier),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_a    <= '0;
      m_b    <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_st) begin
        m_busy <= (model_lat != 0);
        m_cnt  <= model_lat;
        m_a    <= mul_mcand;
        m_b    <= mul_mplier;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_prod <= {4'b0, m_a} * {4'b0, m_b};
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign mul_done    = m_done | spur_done;
  assign mul_product = m_prod;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1; returns once a grant is visible or the budget runs out.
  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      if (req_ready != '0) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                       input int lat, input logic [7:0] exp_p, input logic exp_e,
                       input int exp_k, input bit spur);
    int  k;
    int  extra_st;
    int  hold_bad;
    bit  got;
    logic [1:0]  held_id;
    logic [7:0]  held_p;
    @(negedge clk);
    model_lat  = lat;
    req_valid  = '0;
    req_valid[id] = 1'b1;
    req_mcand  = '0;
    req_mplier = '0;
    req_mcand[id*4 +: 4]  = a;
    req_mplier[id*4 +: 4] = b;
    #1;
    wait_grant();
    chk("grant", req_ready, 32'd1 << id);
    @(negedge clk);
    req_valid = '0;
    spur_done = spur;
    #1;
    chk("mul_st", mul_st, 1);
    chk("issue_a", mul_mcand, a);
    chk("issue_b", mul_mplier, b);
    k = 0; extra_st = 0; hold_bad = 0; got = 0;
    for (int i = 0; i < TIMEOUT + 10 && !got; i++) begin
      @(negedge clk);
      spur_done = 1'b0;
      #1;
      k++;
      if (mul_st) extra_st++;
      if (mul_mcand !== a || mul_mplier !== b) hold_bad++;
      if (rsp_valid) got = 1;
    end
    chk("rsp_seen", got, 1);
    chk("latency", k, exp_k);
    chk("extra_st", extra_st, 0);
    chk("op_hold", hold_bad, 0);
    chk("rsp_id", rsp_id, id);
    chk("rsp_product", rsp_product, exp_p);
    chk("rsp_err", rsp_err, exp_e);
    $display("op id=%0d %0d*%0d -> id=%0d product=%0d err=%0d cycles=%0d",
             id, a, b, rsp_id, rsp_product, rsp_err, k);
    held_id = rsp_id;
    held_p  = rsp_product;
    spur_done = spur;
    @(negedge clk);
    #1;
    chk("rsp_pulse", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("hold_id", rsp_id, held_id);
    chk("hold_product", rsp_product, held_p);
    @(negedge clk);
    spur_done = 1'b0;
    #1;
    chk("idle_no_rsp", rsp_valid, 0);
    chk("idle_no_st", mul_st, 0);
  endtask

  initial begin
    int exp_g [5];
    int exp_p [5];
    int rsp_cnt;
    exp_g = '{0, 1, 2, 3, 0};
    exp_p = '{3, 6, 9, 12, 3};

    // Reset state with all requests asserted.
    req_valid  = '1;
    req_mcand  = '1;
    req_mplier = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_st", mul_st, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mcand", mul_mcand, 0);
    chk("rst_mplier", mul_mplier, 0);
    chk("rst_product", rsp_product, 0);
    chk("rst_err", rsp_err, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", req_ready, 0);

    do_op(2, 4'd7,  4'd5,  2, 8'd35,  1'b0, 4, 1'b0);
    do_op(3, 4'd15, 4'd15, 3, 8'd225, 1'b0, 5, 1'b0);
    do_op(0, 4'd0,  4'd9,  4, 8'd0,   1'b0, 6, 1'b1);
    do_op(1, 4'd1,  4'd15, 1, 8'd15,  1'b0, 3, 1'b0);
    do_op(0, 4'd6,  4'd7,  0, 8'd0,   1'b1, TIMEOUT + 1, 1'b0);
    do_op(3, 4'd13, 4'd11, 2, 8'd143, 1'b0, 4, 1'b0);

    // Reset in the middle of WAIT while every requester is asserting.
    @(negedge clk);
    model_lat  = 20;
    req_valid  = 4'b0010;
    req_mcand  = 16'h0090;
    req_mplier = 16'h0090;
    #1;
    wait_grant();
    chk("mid_grant", req_ready, 4'b0010);
    repeat (3) @(negedge clk);
    req_valid = '1;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_st", mul_st, 0);
    chk("mid_rst_mcand", mul_mcand, 0);
    chk("mid_rst_mplier", mul_mplier, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_product", rsp_product, 0);
    chk("mid_rst_err", rsp_err, 0);
    $display("reset asserted mid-WAIT, outputs cleared");
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_cnt   = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) rsp_cnt++;
    end
    chk("mid_rst_no_rsp", rsp_cnt, 0);

    // Fairness: all four held; first grant after reset must be requester 0.
    @(negedge clk);
    model_lat  = 1;
    req_mcand  = 16'h4321;
    req_mplier = 16'h3333;
    req_valid  = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      wait_grant();
      chk("fair_grant", req_ready, 32'd1 << exp_g[g]);
      @(negedge clk);
      #1;
      chk("fair_quiet", req_ready, 0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #1;
        if (rsp_valid) break;
      end
      chk("fair_rsp", rsp_valid, 1);
      chk("fair_id", rsp_id, exp_g[g]);
      chk("fair_product", rsp_product, exp_p[g]);
      $display("fair grant=%0d -> id=%0d product=%0d", exp_g[g], rsp_id, rsp_product);
      @(negedge clk);
      #1;
      chk("fair_single_rsp", rsp_valid, 0);
    end
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
